// File: rtl/frame_config_sequencer.sv
// frame_config_sequencer: loads a command-selected run of configuration frames
// into one fabric column. Each accepted word is registered onto FrameData, then
// exactly one FrameStrobe bit pulses for one cycle. FrameData stays stable for a
// cycle before the strobe rises and for a cycle after it falls.
// Optional feature: define FRAME_CONFIG_CHECKSUM_EN to require one trailing word
// that must equal the XOR of all frame words of the command.
module frame_config_sequencer #(
    parameter int FRAME_BITS_PER_ROW = 32,
    parameter int MAX_FRAMES_PER_COL = 20,
    parameter int FRAME_IDX_W        = 5
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [FRAME_IDX_W-1:0]        cmd_first,
    input  logic [FRAME_IDX_W-1:0]        cmd_count,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic [FRAME_BITS_PER_ROW-1:0] data_word,
    input  logic                          abort,
    output logic [FRAME_BITS_PER_ROW-1:0] FrameData,
    output logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    // Range limit widened by one bit so first+count cannot wrap.
    localparam logic [FRAME_IDX_W:0] MAX_SUM = (FRAME_IDX_W+1)'(MAX_FRAMES_PER_COL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STROBE,
        S_HOLD,
`ifdef FRAME_CONFIG_CHECKSUM_EN
        S_CHECK,
`endif
        S_FIN
    } state_t;

    state_t                          state, state_nxt;
    logic [FRAME_IDX_W-1:0]          idx, idx_nxt;
    logic [FRAME_IDX_W-1:0]          remaining, remaining_nxt;
    logic                            load_word;
    logic                            cmd_accept;
    logic [MAX_FRAMES_PER_COL-1:0]   strobe_nxt;

    // A command overruns the column if its last frame lies past the final strobe line.
    function automatic logic range_bad(input logic [FRAME_IDX_W-1:0] first,
                                       input logic [FRAME_IDX_W-1:0] count);
        logic [FRAME_IDX_W:0] sum;
        sum = {1'b0, first} + {1'b0, count};
        return (sum > MAX_SUM);
    endfunction

    // One-hot strobe pattern for a frame index; out-of-range indices give zero.
    function automatic logic [MAX_FRAMES_PER_COL-1:0] idx_onehot(input logic [FRAME_IDX_W-1:0] i);
        logic [MAX_FRAMES_PER_COL-1:0] v;
        v = '0;
        for (int k = 0; k < MAX_FRAMES_PER_COL; k++) begin
            if (i == FRAME_IDX_W'(k)) v[k] = 1'b1;
        end
        return v;
    endfunction

`ifdef FRAME_CONFIG_CHECKSUM_EN
    logic [FRAME_BITS_PER_ROW-1:0]   csum;

    // Running XOR of the frame words accepted for the current command.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (cmd_accept) begin
            csum <= '0;
        end else if (load_word) begin
            csum <= csum ^ data_word;
        end
    end
`endif

    // Next-state, handshake and pulse decode; abort always returns to IDLE.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        remaining_nxt = remaining;
        cmd_ready     = 1'b0;
        data_ready    = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        load_word     = 1'b0;
        cmd_accept    = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (range_bad(cmd_first, cmd_count)) begin
                        err = 1'b1;
                    end else if (cmd_count == '0) begin
                        state_nxt = S_FIN;
                    end else begin
                        cmd_accept    = 1'b1;
                        idx_nxt       = cmd_first;
                        remaining_nxt = cmd_count;
                        state_nxt     = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    data_ready = 1'b1;
                    if (data_valid) begin
                        load_word = 1'b1;
                        state_nxt = S_STROBE;
                    end
                end
            end
            S_STROBE: begin
                state_nxt = abort ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    idx_nxt       = idx + FRAME_IDX_W'(1);
                    remaining_nxt = remaining - FRAME_IDX_W'(1);
                    if (remaining == FRAME_IDX_W'(1)) begin
`ifdef FRAME_CONFIG_CHECKSUM_EN
                        state_nxt = S_CHECK;
`else
                        state_nxt = S_FIN;
`endif
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
`ifdef FRAME_CONFIG_CHECKSUM_EN
            S_CHECK: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    data_ready = 1'b1;
                    if (data_valid) begin
                        if (data_word == csum) begin
                            state_nxt = S_FIN;
                        end else begin
                            err       = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end
                end
            end
`endif
            S_FIN: begin
                done      = ~abort;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The strobe is registered from the STROBE state so it rises one cycle after FrameData settles.
    always_comb begin
        strobe_nxt = '0;
        if (state == S_STROBE && !abort) strobe_nxt = idx_onehot(idx);
    end

    assign busy = (state != S_IDLE);

    // Control state: FSM register, frame index and frames-left counter.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Frame word register; holds its value through strobe, hold and abort.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            FrameData <= '0;
        end else if (load_word) begin
            FrameData <= data_word;
        end
    end

    // Strobe register; async reset drops any in-flight strobe immediately.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            FrameStrobe <= '0;
        end else begin
            FrameStrobe <= strobe_nxt;
        end
    end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Randomised self-checking bench for frame_config_sequencer. Expected behaviour
// comes from the command rules: range check on first+count, strobe index
// first+i for word i, fixed per-frame timing, XOR checksum when enabled.
module tb_frame_config_sequencer;

    localparam int W    = 32;
    localparam int MAXF = 20;
    localparam int IW   = 5;

    logic          CLK = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [IW-1:0] cmd_first, cmd_count;
    logic          data_valid, data_ready;
    logic [W-1:0]  data_word;
    logic          abort;
    logic [W-1:0]  FrameData;
    logic [MAXF-1:0] FrameStrobe;
    logic          busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] wq[$];
    bit           hold_pending = 1'b0;
    logic [W-1:0] prev_word;

    frame_config_sequencer #(
        .FRAME_BITS_PER_ROW(W),
        .MAX_FRAMES_PER_COL(MAXF),
        .FRAME_IDX_W(IW)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_first(cmd_first),
        .cmd_count(cmd_count),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .data_word(data_word),
        .abort(abort),
        .FrameData(FrameData),
        .FrameStrobe(FrameStrobe),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Leave the task one time unit after a rising edge, ready to drive.
    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    // Cycle after a strobe: strobe low and the word still held.
    task automatic hold_chk();
        if (hold_pending) begin
            check("hold_strobe", FrameStrobe, 0);
            check("hold_data", FrameData, prev_word);
            hold_pending = 1'b0;
        end
    endtask

    function automatic logic [MAXF-1:0] exp_strobe(input int i);
        logic [MAXF-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic run_cmd(input int first, input int count, input int gmin, input int gmax,
                           input bit bad_csum);
        logic [W-1:0] w[$];
        logic [W-1:0] xr;
        bit           exp_bad;
        int           g;
        exp_bad = (first + count) > MAXF;
        w = wq;
        wq = {};
        while (w.size() < count) w.push_back(W'($urandom));
        xr = '0;
        for (int k = 0; k < count; k++) xr ^= w[k];

        cmd_valid = 1'b1; cmd_first = IW'(first); cmd_count = IW'(count); data_valid = 1'b0;
        settle();
        hold_chk();
        check("cmd_ready", cmd_ready, 1);
        check("cmd_busy", busy, 0);
        check("cmd_err", err, exp_bad);
        nxt();
        cmd_valid = 1'b0;
        if (exp_bad) begin
            settle();
            check("rej_busy", busy, 0);
            check("rej_strobe", FrameStrobe, 0);
            check("rej_done", done, 0);
            check("rej_err_once", err, 0);
            nxt();
            return;
        end
        if (count == 0) begin
            settle();
            check("zero_done", done, 1);
            check("zero_strobe", FrameStrobe, 0);
            nxt();
            settle();
            check("zero_done_once", done, 0);
            check("zero_busy", busy, 0);
            nxt();
            return;
        end
        for (int i = 0; i < count; i++) begin
            g = $urandom_range(gmax, gmin);
            for (int k = 0; k < g; k++) begin
                data_valid = 1'b0; data_word = W'($urandom);
                settle();
                hold_chk();
                check("bp_ready", data_ready, 1);
                check("bp_busy", busy, 1);
                check("bp_strobe", FrameStrobe, 0);
                nxt();
            end
            data_valid = 1'b1; data_word = w[i];
            settle();
            hold_chk();
            check("acc_ready", data_ready, 1);
            check("acc_done", done, 0);
            nxt();
            data_valid = 1'($urandom); data_word = W'($urandom);
            settle();
            check("stb_ready", data_ready, 0);
            check("stb_pre", FrameStrobe, 0);
            check("stb_data", FrameData, w[i]);
            nxt();
            data_valid = 1'($urandom);
            settle();
            check("hi_strobe", FrameStrobe, exp_strobe(first + i));
            check("hi_data", FrameData, w[i]);
            check("hi_ready", data_ready, 0);
            nxt();
            hold_pending = 1'b1;
            prev_word = w[i];
        end
`ifdef FRAME_CONFIG_CHECKSUM_EN
        g = $urandom_range(gmax, gmin);
        for (int k = 0; k < g; k++) begin
            data_valid = 1'b0;
            settle();
            hold_chk();
            check("ck_wait_ready", data_ready, 1);
            check("ck_wait_done", done, 0);
            nxt();
        end
        data_valid = 1'b1; data_word = bad_csum ? (xr ^ W'(1)) : xr;
        settle();
        hold_chk();
        check("ck_ready", data_ready, 1);
        check("ck_err", err, bad_csum);
        check("ck_strobe", FrameStrobe, 0);
        nxt();
        data_valid = 1'b0;
        settle();
        check("ck_fd_held", FrameData, w[count-1]);
        if (bad_csum) begin
            check("ck_bad_busy", busy, 0);
            check("ck_bad_done", done, 0);
            check("ck_err_once", err, 0);
            nxt();
        end else begin
            check("ck_done", done, 1);
            nxt();
            settle();
            check("ck_done_once", done, 0);
            check("ck_idle", busy, 0);
            nxt();
        end
`else
        data_valid = 1'($urandom); data_word = W'($urandom);
        settle();
        hold_chk();
        check("fin_done", done, 1);
        check("fin_ready", data_ready, 0);
        check("fin_busy", busy, 1);
        nxt();
        data_valid = 1'b0;
        settle();
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_data", FrameData, w[count-1]);
        nxt();
`endif
        if (bad_csum) hold_pending = 1'b0;
    endtask

    // Abort in STROBE of frame 2 of 5, then abort colliding with data_valid in LOAD.
    task automatic abort_test();
        logic [W-1:0] w0, w1;
        w0 = W'($urandom); w1 = W'($urandom);
        cmd_valid = 1'b1; cmd_first = IW'(1); cmd_count = IW'(5);
        settle(); nxt();
        cmd_valid = 1'b0;
        data_valid = 1'b1; data_word = w0; settle(); nxt();
        data_valid = 1'b0; settle(); nxt();
        settle();
        check("ab_f0_strobe", FrameStrobe, exp_strobe(1));
        nxt();
        data_valid = 1'b1; data_word = w1;
        settle();
        check("ab_f1_ready", data_ready, 1);
        nxt();
        data_valid = 1'b0; abort = 1'b1;
        settle();
        check("ab_busy_stb", busy, 1);
        nxt();
        abort = 1'b0;
        settle();
        check("ab_strobe_next", FrameStrobe, 0);
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        check("ab_data", FrameData, w1);
        nxt();
        for (int k = 0; k < 4; k++) begin
            data_valid = 1'b1; data_word = W'($urandom);
            settle();
            check("ab_quiet_strobe", FrameStrobe, 0);
            check("ab_quiet_done", done, 0);
            check("ab_quiet_ready", data_ready, 0);
            nxt();
        end
        data_valid = 1'b0;
        cmd_valid = 1'b1; cmd_first = IW'(0); cmd_count = IW'(2);
        settle(); nxt();
        cmd_valid = 1'b0;
        data_valid = 1'b1; abort = 1'b1; data_word = ~w1;
        settle();
        check("ab_ld_ready", data_ready, 0);
        nxt();
        abort = 1'b0; data_valid = 1'b0;
        settle();
        check("ab_ld_busy", busy, 0);
        check("ab_ld_data", FrameData, w1);
        nxt();
        for (int k = 0; k < 3; k++) begin
            settle();
            check("ab_ld_strobe", FrameStrobe, 0);
            nxt();
        end
    endtask

    // Asynchronous reset while a strobe is high.
    task automatic reset_test();
        logic [W-1:0] w0;
        w0 = W'($urandom);
        cmd_valid = 1'b1; cmd_first = IW'(2); cmd_count = IW'(3);
        settle(); nxt();
        cmd_valid = 1'b0;
        data_valid = 1'b1; data_word = w0; settle(); nxt();
        data_valid = 1'b0; settle(); nxt();
        settle();
        check("rst_pre_strobe", FrameStrobe, exp_strobe(2));
        #1 reset = 1'b1;
        #1;
        check("rst_async_strobe", FrameStrobe, 0);
        check("rst_async_data", FrameData, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_done", done, 0);
        check("rst_async_err", err, 0);
        nxt();
        reset = 1'b0;
        settle();
        check("rst_idle_ready", cmd_ready, 1);
        check("rst_idle_strobe", FrameStrobe, 0);
        nxt();
        hold_pending = 1'b0;
    endtask

    initial begin
        int f, c;
        reset = 1'b1; cmd_valid = 1'b0; cmd_first = '0; cmd_count = '0;
        data_valid = 1'b0; data_word = '0; abort = 1'b0;
        #12;
        check("rst_FrameData", FrameData, 0);
        check("rst_FrameStrobe", FrameStrobe, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_data_ready", data_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        nxt();
        reset = 1'b0;
        nxt();

        wq = {32'hA5A5_0F0F};
        run_cmd(3, 1, 0, 0, 1'b0);

        wq = {};
        for (int k = 0; k < 20; k++) wq.push_back(W'(k));
        run_cmd(0, 20, 1, 1, 1'b0);

        run_cmd(15, 6, 0, 0, 1'b0);
        run_cmd(7, 0, 0, 0, 1'b0);

        run_cmd(4, 2, 10, 10, 1'b0);

        abort_test();
        reset_test();

`ifdef FRAME_CONFIG_CHECKSUM_EN
        wq = {32'h1, 32'h2, 32'h4};
        run_cmd(0, 3, 0, 0, 1'b0);
        wq = {32'h1, 32'h2, 32'h4};
        run_cmd(0, 3, 0, 0, 1'b1);
`endif

        for (int r = 0; r < 30; r++) begin
            f = $urandom_range(19, 0);
            c = $urandom_range(21 - f, 0);
            run_cmd(f, c, 0, 2, 1'($urandom));
        end
        run_cmd(20, 1, 0, 0, 1'b0);
        run_cmd(19, 1, 0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
